approx_rc_adder_pipe: RTL and testbench
=======================================

Name: approx_rc_adder_pipe

Overview:
- Parametrised, pipelined ripple-carry adder whose lowest APPROX_BITS positions use the team's approximate full-adder cell (truth table below).
- Remaining positions use exact full adders.
- The carry chain is cut into STAGES registered segments, with valid/ready handshakes at both ends.
- A per-transaction mode bit selects approximate or exact operation. The block sits in the adder-characterisation datapath, feeding the delay/MAE evaluation harness.

Parameters:
WIDTH, 8, operand width in bits (≥2)
APPROX_BITS, 2, number of LSB positions using the approximate cell (0..WIDTH)
STAGES, 2, pipeline segments; WIDTH must be divisible by STAGES (elaboration error otherwise)
ACC_W, 32, error-accumulator width (optional feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  block can accept input this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry-in to bit 0
in_approx  in  1  1 = approximate LSBs, 0 = all positions exact
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_sum  out  WIDTH+1  {carry-out, sum}

Behaviour:
- One clock (clk); reset rst is synchronous and active-high.
- Reset state: all stage valids 0, out_valid=0, out_sum=0. in_ready=1 after reset.
- Approximate cell, inputs X=a_i, Y=b_i, Z=carry_in_i:
  - Cout = Y | Z
  - S = ~Y & (X ^ Z)
- Exact cell: S = X^Y^Z, Cout = majority(X,Y,Z).
- Bit i uses the approximate cell iff i < APPROX_BITS and in_approx=1 for that transaction.
- in_approx travels with the data through the pipeline.
- Segment k covers bits [k*SEG, (k+1)*SEG-1], with SEG = WIDTH/STAGES.
  - Stage k computes its segment from the registered carry of stage k-1.
  - Stage 0 uses in_cin.
  - Unprocessed operand bits and completed sum bits are carried forward in the stage registers.
- Latency: STAGES cycles from in_valid&&in_ready to out_valid (no stall). Throughput: 1 per cycle.
- Handshake:
  - Stage k advances when its own valid is 0, or when the next stage advances.
  - The last stage advances when out_valid=0 or out_ready=1.
  - in_ready = stage-0 advance condition, combinational from the downstream chain; there is no input skid buffer.
  - out_sum and out_valid are held stable while out_valid=1 and out_ready=0.
- out_sum[WIDTH] = final carry-out of the chain (approximate or exact, per mode).
- APPROX_BITS=0, or in_approx=0: the result equals a+b+cin exactly.
- Simultaneous input accept and output drain while full: both occur; there is no bubble.
- Reset mid-operation discards all in-flight transactions. Nothing is emitted after reset.

Optional Feature:
Macro APPROX_ERR_MON_EN.
- When defined:
  - The block computes the exact sum a+b+cin alongside the datapath, pipelined identically.
  - It adds outputs err_abs (WIDTH+1, |approx−exact| aligned with out_sum), err_acc (ACC_W, saturating running sum of err_abs), err_max (WIDTH+1, running maximum) and err_cnt (ACC_W, wrapping count of results).
  - It adds input err_clr (1), a synchronous clear of err_acc, err_max and err_cnt.
  - Monitor registers update on each out_valid&&out_ready handshake.
  - If err_clr and a handshake coincide, the clear wins and that sample is discarded.
  - Reset clears all monitor registers.
- When not defined: none of these ports or logic exist; the data path is unchanged.

Test Plan:
- Defaults, approx=1, a=0x00 b=0x01 cin=0 -> out_sum=0x006 after 2 cycles; with monitor err_abs=5.
- Defaults, approx=1, a=0x03 b=0x01 -> 0x004; a=0x01 b=0x00 -> 0x001; a=0xFF b=0x01 -> 0x100 (all error 0).
- Same as first, approx=0 -> 0x001. Random 1000 vectors with approx=0 -> out_sum == a+b+cin for all.
- Back-to-back stream, out_ready held low 5 cycles mid-stream:
  - in_ready drops after 2 accepted beyond the drained result.
  - The held out_sum is stable.
  - Order is preserved, with no loss or duplication.
- rst asserted with 2 transactions in flight -> out_valid=0 next cycle, no stale outputs afterwards, in_ready=1.
- WIDTH=16 APPROX_BITS=4 STAGES=4: latency 4, matches bit-level reference model. Monitor: err_clr concurrent with handshake -> err_cnt=0, err_acc=0.

Source files
------------

// File: rtl/approx_rc_adder_pipe.sv
// Pipelined ripple-carry adder: approximate cells on the low APPROX_BITS positions, valid/ready at both ends.
// Define APPROX_ERR_MON_EN to add the |approx - exact| error monitor ports (err_clr, err_abs, err_acc, err_max, err_cnt).
module approx_rc_adder_pipe #(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 2,
    parameter int STAGES      = 2,
    parameter int ACC_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum
`ifdef APPROX_ERR_MON_EN
    ,
    input  logic             err_clr,
    output logic [WIDTH:0]   err_abs,
    output logic [ACC_W-1:0] err_acc,
    output logic [WIDTH:0]   err_max,
    output logic [ACC_W-1:0] err_cnt
`endif
);
    localparam int SEG = WIDTH / STAGES;

    if (WIDTH < 2) begin : g_bad_width
        $error("approx_rc_adder_pipe: WIDTH must be at least 2");
    end
    if (APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_bad_approx
        $error("approx_rc_adder_pipe: APPROX_BITS must lie in 0..WIDTH");
    end
    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_stages
        $error("approx_rc_adder_pipe: WIDTH must be divisible by STAGES");
    end

    // Each stage register carries the untouched operand bits forward and accumulates finished sum bits.
    typedef struct packed {
        logic             approx;
        logic             carry;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
`ifdef APPROX_ERR_MON_EN
        logic             ex_carry;
        logic [WIDTH-1:0] ex_sum;
`endif
    } stage_t;

    // Ripples one segment; position base+j uses the approximate cell when approx is set and it is below APPROX_BITS.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                             input logic cin, input logic approx, input int base);
        logic           c;
        logic [SEG-1:0] s;
        c = cin;
        s = '0;
        for (int j = 0; j < SEG; j++) begin
            if (approx && (base + j) < APPROX_BITS) begin
                s[j] = ~b[j] & (a[j] ^ c);
                c    = b[j] | c;
            end else begin
                s[j] = a[j] ^ b[j] ^ c;
                c    = (a[j] & b[j]) | (a[j] & c) | (b[j] & c);
            end
        end
        return {c, s};
    endfunction

    stage_t            stage_q [STAGES];
    stage_t            src     [STAGES];
    stage_t            stage_d [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] up_valid;
    logic [STAGES-1:0] adv;

    always_comb begin
        logic [SEG:0] r;
        // NOTE: every variable written here gets a value on every path first, so no latch can be inferred.
        r      = '0;
        src[0] = '0;
        src[0].approx = in_approx;
        src[0].carry  = in_cin;
        src[0].a      = in_a;
        src[0].b      = in_b;
`ifdef APPROX_ERR_MON_EN
        src[0].ex_carry = in_cin;
`endif
        for (int k = 1; k < STAGES; k++) src[k] = stage_q[k-1];
        for (int k = 0; k < STAGES; k++) begin
            stage_d[k] = src[k];
            r = seg_add(src[k].a[k*SEG +: SEG], src[k].b[k*SEG +: SEG], src[k].carry, src[k].approx, k*SEG);
            stage_d[k].sum[k*SEG +: SEG] = r[SEG-1:0];
            stage_d[k].carry             = r[SEG];
`ifdef APPROX_ERR_MON_EN
            r = seg_add(src[k].a[k*SEG +: SEG], src[k].b[k*SEG +: SEG], src[k].ex_carry, 1'b0, k*SEG);
            stage_d[k].ex_sum[k*SEG +: SEG] = r[SEG-1:0];
            stage_d[k].ex_carry             = r[SEG];
`endif
        end
    end

    // A stage may advance if it or any stage downstream of it is empty, or the output is being taken.
    always_comb begin
        logic room;
        room        = out_ready;
        up_valid[0] = in_valid;
        for (int k = 1; k < STAGES; k++) up_valid[k] = valid_q[k-1];
        for (int k = STAGES - 1; k >= 0; k--) begin
            room   = room | ~valid_q[k];
            adv[k] = room;
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_sum   = {stage_q[STAGES-1].carry, stage_q[STAGES-1].sum};

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            // NOTE: the data registers are reset as well because out_sum must read zero after reset.
            for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    // NOTE: non-blocking updates let every stage sample its upstream neighbour's old value.
                    valid_q[k] <= up_valid[k];
                    if (up_valid[k]) stage_q[k] <= stage_d[k];
                end
            end
        end
    end

`ifdef APPROX_ERR_MON_EN
    if (ACC_W < WIDTH + 1) begin : g_bad_acc
        $error("approx_rc_adder_pipe: ACC_W must be at least WIDTH+1");
    end

    logic [WIDTH:0]   exact_res;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] err_acc_q;
    logic [ACC_W-1:0] err_cnt_q;
    logic [WIDTH:0]   err_max_q;

    assign exact_res = {stage_q[STAGES-1].ex_carry, stage_q[STAGES-1].ex_sum};
    assign err_abs   = (out_sum >= exact_res) ? out_sum - exact_res : exact_res - out_sum;
    assign acc_sum   = {1'b0, err_acc_q} + (ACC_W+1)'(err_abs);
    assign err_acc   = err_acc_q;
    assign err_max   = err_max_q;
    assign err_cnt   = err_cnt_q;

    // A clear coinciding with a handshake wins; that sample is dropped.
    always_ff @(posedge clk) begin
        if (rst || err_clr) begin
            err_acc_q <= '0;
            err_max_q <= '0;
            err_cnt_q <= '0;
        end else if (out_valid && out_ready) begin
            err_acc_q <= acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
            if (err_abs > err_max_q) err_max_q <= err_abs;
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_approx_rc_adder_pipe.sv
// Scoreboard bench for approx_rc_adder_pipe: an 8-bit default instance and a 16-bit, 4-stage instance.
module tb_approx_rc_adder_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, in_cin, in_approx, out_valid, out_ready;
    logic [7:0]  in_a, in_b;
    logic [8:0]  out_sum;
    logic        w_in_valid, w_in_ready, w_in_cin, w_in_approx, w_out_valid, w_out_ready;
    logic [15:0] w_in_a, w_in_b;
    logic [16:0] w_out_sum;
`ifdef APPROX_ERR_MON_EN
    logic        err_clr, w_err_clr;
    logic [8:0]  err_abs, err_max;
    logic [31:0] err_acc, err_cnt;
    logic [16:0] w_err_abs, w_err_max;
    logic [31:0] w_err_acc, w_err_cnt;
`endif

    approx_rc_adder_pipe #(.WIDTH(8), .APPROX_BITS(2), .STAGES(2), .ACC_W(32)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_approx(in_approx),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
`ifdef APPROX_ERR_MON_EN
        , .err_clr(err_clr), .err_abs(err_abs), .err_acc(err_acc), .err_max(err_max), .err_cnt(err_cnt)
`endif
    );

    approx_rc_adder_pipe #(.WIDTH(16), .APPROX_BITS(4), .STAGES(4), .ACC_W(32)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_a(w_in_a), .in_b(w_in_b),
        .in_cin(w_in_cin), .in_approx(w_in_approx),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_sum(w_out_sum)
`ifdef APPROX_ERR_MON_EN
        , .err_clr(w_err_clr), .err_abs(w_err_abs), .err_acc(w_err_acc), .err_max(w_err_max), .err_cnt(w_err_cnt)
`endif
    );

    typedef struct packed {
        logic [16:0] sum;
        logic [16:0] err;
    } exp_t;

    exp_t q8[$];
    exp_t q16[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-level reference for the 16-bit instance, written straight from the cell truth tables.
    function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic ap);
        logic        c;
        logic [15:0] s;
        c = cin;
        s = '0;
        for (int i = 0; i < 16; i++) begin
            if (ap && i < 4) begin
                s[i] = ~b[i] & (a[i] ^ c);
                c    = b[i] | c;
            end else begin
                s[i] = a[i] ^ b[i] ^ c;
                c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
            end
        end
        return {c, s};
    endfunction

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic ap,
                         input logic [16:0] es, input logic [16:0] ee);
        int   n;
        exp_t e;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_approx = ap;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout8: in_ready stayed 0 for %0d cycles", n);
        end else begin
            e.sum = es; e.err = ee;
            q8.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic ap,
                          input logic [16:0] es, input logic [16:0] ee);
        int   n;
        exp_t e;
        w_in_valid = 1'b1; w_in_a = a; w_in_b = b; w_in_cin = cin; w_in_approx = ap;
        n = 0;
        @(negedge clk);
        while (!w_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!w_in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout16: in_ready stayed 0 for %0d cycles", n);
        end else begin
            e.sum = es; e.err = ee;
            q16.push_back(e);
        end
        @(posedge clk); #1;
        w_in_valid = 1'b0;
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while (q8.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q8.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain8: %0d results never appeared", q8.size());
            q8.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic drain16();
        int n;
        n = 0;
        while (q16.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (q16.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain16: %0d results never appeared", q16.size());
            q16.delete();
        end
        @(posedge clk); #1;
    endtask

    // Monitor for the 8-bit instance: pops on each handshake and checks that a stalled result holds.
    initial begin : mon8
        logic       held;
        logic [8:0] held_sum;
        exp_t       e;
        held = 1'b0;
        held_sum = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid8", {31'd0, out_valid}, 32'd1);
                    check("hold_sum8", {23'd0, out_sum}, {23'd0, held_sum});
                end
                held = 1'b0;
                if (out_valid && out_ready) begin
                    if (q8.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_out8: got out_sum=0x%0h with nothing expected", out_sum);
                    end else begin
                        e = q8.pop_front();
                        check("sum8", {23'd0, out_sum}, {15'd0, e.sum});
`ifdef APPROX_ERR_MON_EN
                        check("err_abs8", {23'd0, err_abs}, {15'd0, e.err});
`endif
                    end
                end else if (out_valid) begin
                    held = 1'b1;
                    held_sum = out_sum;
                end
            end
        end
    end

    initial begin : mon16
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && w_out_valid && w_out_ready) begin
                if (q16.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out16: got out_sum=0x%0h with nothing expected", w_out_sum);
                end else begin
                    e = q16.pop_front();
                    check("sum16", {15'd0, w_out_sum}, {15'd0, e.sum});
`ifdef APPROX_ERR_MON_EN
                    check("err_abs16", {15'd0, w_err_abs}, {15'd0, e.err});
`endif
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          lat;
        int          acc;
        int          n;
        logic [7:0]  ra, rb;
        logic        rc;
        logic [15:0] wa, wb;
        logic [16:0] wr, we;
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_approx = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_a = '0; w_in_b = '0; w_in_cin = 1'b0; w_in_approx = 1'b0; w_out_ready = 1'b1;
`ifdef APPROX_ERR_MON_EN
        err_clr = 1'b0; w_err_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid8", {31'd0, out_valid}, 32'd0);
        check("reset_out_sum8", {23'd0, out_sum}, 32'd0);
        check("reset_in_ready8", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid16", {31'd0, w_out_valid}, 32'd0);
        check("reset_in_ready16", {31'd0, w_in_ready}, 32'd1);
        @(posedge clk); #1;

        // Hand-computed default-configuration vectors: {a, b, cin, approx} -> {sum, |error|}.
        send8(8'h00, 8'h01, 1'b0, 1'b1, 17'h006, 17'd5);
        send8(8'h03, 8'h01, 1'b0, 1'b1, 17'h004, 17'd0);
        send8(8'h01, 8'h00, 1'b0, 1'b1, 17'h001, 17'd0);
        send8(8'hFF, 8'h01, 1'b0, 1'b1, 17'h100, 17'd0);
        send8(8'h00, 8'h01, 1'b0, 1'b0, 17'h001, 17'd0);
        send8(8'h00, 8'h00, 1'b1, 1'b1, 17'h007, 17'd6);
        send8(8'h55, 8'hAA, 1'b1, 1'b1, 17'h100, 17'd0);
        send8(8'h55, 8'hAA, 1'b1, 1'b0, 17'h100, 17'd0);
        drain8();

        send8(8'h00, 8'h01, 1'b0, 1'b1, 17'h006, 17'd5);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 20);
        check("latency8", lat, 32'd2);
        @(posedge clk); #1;
        drain8();

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            send8(ra, rb, rc, 1'b0, 17'(ra) + 17'(rb) + 17'(rc), 17'd0);
        end
        drain8();

        // Stall from an empty pipe: two accepts fill both stages, then in_ready must drop.
        out_ready = 1'b0;
        acc = 0;
        fork
            begin
                send8(8'h01, 8'h00, 1'b0, 1'b0, 17'h001, 17'd0);
                send8(8'h11, 8'h02, 1'b0, 1'b0, 17'h013, 17'd0);
                send8(8'h21, 8'h04, 1'b0, 1'b0, 17'h025, 17'd0);
                send8(8'h31, 8'h06, 1'b0, 1'b0, 17'h037, 17'd0);
            end
            begin
                repeat (5) begin
                    @(negedge clk);
                    if (in_valid && in_ready) acc++;
                end
                check("stall_accepts", acc, 32'd2);
                check("stall_in_ready", {31'd0, in_ready}, 32'd0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain8();

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        send8(8'h10, 8'h20, 1'b0, 1'b0, 17'h030, 17'd0);
        send8(8'h01, 8'h01, 1'b0, 1'b0, 17'h002, 17'd0);
        rst = 1'b1;
        q8.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum", {23'd0, out_sum}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("rst_no_stale", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

`ifdef APPROX_ERR_MON_EN
        send8(8'h00, 8'h01, 1'b0, 1'b1, 17'h006, 17'd5);
        send8(8'h00, 8'h00, 1'b1, 1'b1, 17'h007, 17'd6);
        drain8();
        check("err_cnt", err_cnt, 32'd2);
        check("err_acc", err_acc, 32'd11);
        check("err_max", {23'd0, err_max}, 32'd6);
        send8(8'h00, 8'h01, 1'b0, 1'b1, 17'h006, 17'd5);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check("clr_err_cnt", err_cnt, 32'd0);
        check("clr_err_acc", err_acc, 32'd0);
        check("clr_err_max", {23'd0, err_max}, 32'd0);
        @(posedge clk); #1;
        drain8();
`endif

        // 16-bit, 4 approximate positions, 4 stages.
        send16(16'h0000, 16'h000F, 1'b0, 1'b1, 17'h00010, 17'd1);
        send16(16'h000F, 16'h0000, 1'b0, 1'b1, 17'h0000F, 17'd0);
        send16(16'hFFFF, 16'h0001, 1'b0, 1'b1, 17'h10000, 17'd0);
        send16(16'h0000, 16'h0000, 1'b1, 1'b1, 17'h0001F, 17'h1E);
        send16(16'h1234, 16'hFEDC, 1'b1, 1'b0, 17'h11111, 17'd0);
        send16(16'h1234, 16'hFEDC, 1'b1, 1'b1, 17'h11113, 17'd2);
        drain16();

        send16(16'h0000, 16'h000F, 1'b0, 1'b1, 17'h00010, 17'd1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!w_out_valid && lat < 20);
        check("latency16", lat, 32'd4);
        @(posedge clk); #1;
        drain16();

        for (int i = 0; i < 50; i++) begin
            wa = 16'($urandom);
            wb = 16'($urandom);
            rc = 1'($urandom);
            wr = ref16(wa, wb, rc, 1'b1);
            we = 17'(wa) + 17'(wb) + 17'(rc);
            send16(wa, wb, rc, 1'b1, wr, (wr >= we) ? wr - we : we - wr);
        end
        drain16();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
